// File: rtl/irq_prio_ctrl.sv
// Interrupt scheduler: selects one pending, enabled source (fixed priority or
// round-robin), runs the CPU req/ack/done handshake and pulses a clear back.
module irq_prio_ctrl #(
    parameter int NSRC = 8,
    parameter int IDW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src_pend,
    output logic [NSRC-1:0] src_clr,
    output logic            cpu_irq,
    output logic [IDW-1:0]  cpu_id,
    input  logic            cpu_ack,
    input  logic            cpu_done,
    input  logic            i_wb_cyc,
    input  logic [1:0]      i_wb_addr,
    input  logic            i_wb_we,
    input  logic [7:0]      i_wb_data,
    output logic [7:0]      o_wb_rdt,
    output logic            o_wb_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        REQ   = 2'd2,
        SERVE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] en_q, en_d;
    logic            gen_q, gen_d;
    logic            rr_q, rr_d;
    logic [IDW-1:0]  rrptr_q, rrptr_d;
    logic [IDW-1:0]  cpu_id_q, cpu_id_d;
    logic            cpu_irq_q, cpu_irq_d;
    logic [NSRC-1:0] src_clr_q, src_clr_d;
    logic            wb_ack_q, wb_ack_d;

    logic [NSRC-1:0] eligible;
    logic [IDW-1:0]  lo_id, hi_id, win_id;
    logic            hi_found;
    logic            id_eligible;
    logic [IDW-1:0]  rrptr_next;

    assign eligible    = src_pend & en_q & {NSRC{gen_q}};
    assign id_eligible = eligible[cpu_id_q];
    assign rrptr_next  = (cpu_id_q == IDW'(NSRC - 1)) ? '0 : cpu_id_q + IDW'(1);

    // Lowest eligible overall, and lowest eligible at or above the RR pointer;
    // round-robin falls back to the overall lowest when nothing sits above.
    always_comb begin
        lo_id    = '0;
        hi_id    = '0;
        hi_found = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lo_id = IDW'(i);
                if (IDW'(i) >= rrptr_q) begin
                    hi_id    = IDW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        win_id = (rr_q && hi_found) ? hi_id : lo_id;
    end

    always_comb begin
        state_d   = state_q;
        cpu_id_d  = cpu_id_q;
        cpu_irq_d = cpu_irq_q;
        src_clr_d = '0;
        rrptr_d   = rrptr_q;
        case (state_q)
            IDLE: begin
                if (|eligible) state_d = ARB;
            end
            ARB: begin
                if (|eligible) begin
                    cpu_id_d  = win_id;
                    cpu_irq_d = 1'b1;
                    state_d   = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                // An ack beats a simultaneous withdrawal.
                if (cpu_ack) begin
                    cpu_irq_d = 1'b0;
                    src_clr_d = {{(NSRC-1){1'b0}}, 1'b1} << cpu_id_q;
                    if (rr_q) rrptr_d = rrptr_next;
                    state_d   = SERVE;
                end else if (!id_eligible) begin
                    cpu_irq_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            SERVE: begin
                if (cpu_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        en_d     = en_q;
        gen_d    = gen_q;
        rr_d     = rr_q;
        wb_ack_d = i_wb_cyc & ~wb_ack_q;
        if (i_wb_we && wb_ack_q) begin
            case (i_wb_addr)
                2'd0: en_d = i_wb_data[NSRC-1:0];
                2'd1: begin
                    gen_d = i_wb_data[0];
                    rr_d  = i_wb_data[1];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_wb_rdt = 8'h00;
        case (i_wb_addr)
            2'd0: o_wb_rdt = 8'(en_q);
            2'd1: o_wb_rdt = {6'b0, rr_q, gen_q};
            2'd2: o_wb_rdt = {state_q, 3'b000, 3'(cpu_id_q)};
            2'd3: o_wb_rdt = 8'(rrptr_q);
            default: o_wb_rdt = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            en_q      <= '0;
            gen_q     <= 1'b0;
            rr_q      <= 1'b0;
            rrptr_q   <= '0;
            cpu_id_q  <= '0;
            cpu_irq_q <= 1'b0;
            src_clr_q <= '0;
            wb_ack_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            gen_q     <= gen_d;
            rr_q      <= rr_d;
            rrptr_q   <= rrptr_d;
            cpu_id_q  <= cpu_id_d;
            cpu_irq_q <= cpu_irq_d;
            src_clr_q <= src_clr_d;
            wb_ack_q  <= wb_ack_d;
        end
    end

    assign cpu_irq  = cpu_irq_q;
    assign cpu_id   = cpu_id_q;
    assign src_clr  = src_clr_q;
    assign o_wb_ack = wb_ack_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Bench for irq_prio_ctrl: directed handshake scenarios plus a randomized run,
// all checked every cycle against a behavioural model of the scheduler.
module tb_irq_prio_ctrl;
    localparam int NSRC = 8;
    localparam int IDW  = 3;
    localparam logic [7:0] MASK = 8'((1 << NSRC) - 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     src_pend = '0;
    logic [7:0]     src_clr;
    logic           cpu_irq;
    logic [IDW-1:0] cpu_id;
    logic           cpu_ack = 1'b0;
    logic           cpu_done = 1'b0;
    logic           i_wb_cyc = 1'b0;
    logic [1:0]     i_wb_addr = '0;
    logic           i_wb_we = 1'b0;
    logic [7:0]     i_wb_data = '0;
    logic [7:0]     o_wb_rdt;
    logic           o_wb_ack;

    int checks = 0;
    int errors = 0;

    irq_prio_ctrl #(.NSRC(NSRC), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .src_pend(src_pend), .src_clr(src_clr),
        .cpu_irq(cpu_irq), .cpu_id(cpu_id), .cpu_ack(cpu_ack), .cpu_done(cpu_done),
        .i_wb_cyc(i_wb_cyc), .i_wb_addr(i_wb_addr), .i_wb_we(i_wb_we),
        .i_wb_data(i_wb_data), .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack)
    );

    always #5 clk = ~clk;

    // Behavioural model: state 0 idle, 1 arbitrating, 2 requesting, 3 serving.
    int         m_state = 0;
    int         m_id = 0;
    int         m_ptr = 0;
    logic [7:0] m_en = '0;
    logic       m_gen = 1'b0;
    logic       m_rr = 1'b0;
    logic       m_ack = 1'b0;
    logic [7:0] m_clr = '0;

    function automatic int pick(logic [7:0] e, int start);
        for (int k = 0; k < NSRC; k++) begin
            int idx;
            idx = (start + k) % NSRC;
            if (e[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic logic [7:0] model_rdt(logic [1:0] a);
        case (a)
            2'd0:    return m_en;
            2'd1:    return {6'b0, m_rr, m_gen};
            2'd2:    return 8'((m_state << 6) | (m_id & 7));
            default: return 8'(m_ptr);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [7:0] elig;
        int         ns;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_state = 0; m_id = 0; m_ptr = 0; m_en = '0;
                m_gen = 1'b0; m_rr = 1'b0; m_ack = 1'b0; m_clr = '0;
            end else begin
                elig  = src_pend & m_en & (m_gen ? MASK : 8'h00);
                m_clr = '0;
                ns    = m_state;
                case (m_state)
                    0: if (elig != 0) ns = 1;
                    1: begin
                        if (elig != 0) begin
                            m_id = pick(elig, m_rr ? m_ptr : 0);
                            ns = 2;
                        end else begin
                            ns = 0;
                        end
                    end
                    2: begin
                        if (cpu_ack) begin
                            m_clr = 8'h01 << m_id;
                            if (m_rr) m_ptr = (m_id + 1) % NSRC;
                            ns = 3;
                        end else if (!elig[m_id]) begin
                            ns = 0;
                        end
                    end
                    default: if (cpu_done) ns = 0;
                endcase
                m_state = ns;
                if (i_wb_we && m_ack) begin
                    if (i_wb_addr == 2'd0) m_en = i_wb_data & MASK;
                    if (i_wb_addr == 2'd1) begin
                        m_gen = i_wb_data[0];
                        m_rr  = i_wb_data[1];
                    end
                end
                m_ack = i_wb_cyc && !m_ack;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("cpu_irq", 32'(cpu_irq), 32'(m_state == 2));
                chk("cpu_id", 32'(cpu_id), 32'(m_id));
                chk("src_clr", 32'(src_clr), 32'(m_clr));
                chk("wb_ack", 32'(o_wb_ack), 32'(m_ack));
                chk("wb_rdt", 32'(o_wb_rdt), 32'(model_rdt(i_wb_addr)));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        i_wb_cyc = 1'b1; i_wb_we = 1'b1; i_wb_addr = a; i_wb_data = d;
        step();
        step();
        i_wb_cyc = 1'b0; i_wb_we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string name);
        i_wb_cyc = 1'b1; i_wb_we = 1'b0; i_wb_addr = a;
        step();
        chk({name, "_ack"}, 32'(o_wb_ack), 32'd1);
        chk(name, 32'(o_wb_rdt), 32'(exp));
        i_wb_cyc = 1'b0;
        step();
        chk({name, "_ack_drop"}, 32'(o_wb_ack), 32'd0);
    endtask

    task automatic wait_irq(input int budget, input string name);
        int n;
        n = 0;
        while (!cpu_irq && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (!cpu_irq) begin
            errors++;
            $display("FAIL %s: cpu_irq still 0 after %0d cycles, expected 1", name, budget);
        end
    endtask

    task automatic peek(input logic [1:0] a, input logic [7:0] exp, input string name);
        i_wb_addr = a;
        #1;
        chk(name, 32'(o_wb_rdt), 32'(exp));
    endtask

    initial begin
        logic [7:0] id_exp[4];
        logic [7:0] ptr_exp[4];
        id_exp  = '{8'd0, 8'd7, 8'd0, 8'd7};
        ptr_exp = '{8'd1, 8'd0, 8'd1, 8'd0};

        // Reset and configuration
        repeat (3) step();
        chk("rst_irq", 32'(cpu_irq), 32'd0);
        chk("rst_id", 32'(cpu_id), 32'd0);
        chk("rst_clr", 32'(src_clr), 32'd0);
        chk("rst_ack", 32'(o_wb_ack), 32'd0);
        rst = 1'b0;
        step();
        bus_write(2'd0, 8'hFF);
        bus_write(2'd1, 8'h01);
        bus_read(2'd0, 8'hFF, "rd_en");
        bus_read(2'd1, 8'h01, "rd_ctrl");

        // Fixed priority
        src_pend = 8'h28;
        step();
        chk("fix_lat1", 32'(cpu_irq), 32'd0);
        step();
        chk("fix_irq", 32'(cpu_irq), 32'd1);
        chk("fix_id3", 32'(cpu_id), 32'd3);
        cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        chk("fix_clr", 32'(src_clr), 32'h08);
        chk("fix_irq_off", 32'(cpu_irq), 32'd0);
        src_pend = 8'h20;
        step();
        chk("fix_clr_once", 32'(src_clr), 32'h00);
        cpu_done = 1'b1;
        step();
        cpu_done = 1'b0;
        step();
        chk("fix_gap", 32'(cpu_irq), 32'd0);
        step();
        chk("fix_irq2", 32'(cpu_irq), 32'd1);
        chk("fix_id5", 32'(cpu_id), 32'd5);
        cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        src_pend = 8'h00;
        cpu_done = 1'b1;
        step();
        cpu_done = 1'b0;

        // Round-robin with pendings held
        bus_write(2'd1, 8'h03);
        src_pend = 8'h81;
        for (int j = 0; j < 4; j++) begin
            wait_irq(10, "rr_wait");
            chk("rr_id", 32'(cpu_id), 32'(id_exp[j]));
            cpu_ack = 1'b1;
            step();
            cpu_ack = 1'b0;
            cpu_done = 1'b1;
            step();
            cpu_done = 1'b0;
            bus_read(2'd3, ptr_exp[j], "rr_ptr");
        end
        src_pend = 8'h00;
        repeat (3) step();

        // Masking and withdrawal
        bus_write(2'd0, 8'h00);
        bus_write(2'd1, 8'h01);
        src_pend = 8'h01;
        repeat (4) step();
        chk("mask_irq", 32'(cpu_irq), 32'd0);
        bus_write(2'd0, 8'h01);
        wait_irq(10, "mask_wait");
        chk("mask_id", 32'(cpu_id), 32'd0);
        bus_write(2'd0, 8'h00);
        step();
        chk("wd_irq", 32'(cpu_irq), 32'd0);
        chk("wd_clr", 32'(src_clr), 32'd0);
        peek(2'd2, 8'h00, "wd_stat");

        // Ack simultaneous with withdrawal by GEN clear
        bus_write(2'd0, 8'h01);
        wait_irq(10, "sim_wait");
        bus_write(2'd1, 8'h00);
        cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        chk("sim_clr", 32'(src_clr), 32'h01);
        chk("sim_irq", 32'(cpu_irq), 32'd0);
        peek(2'd2, 8'hC0, "sim_stat");
        cpu_done = 1'b1;
        step();
        cpu_done = 1'b0;

        // cpu_done while requesting is ignored
        bus_write(2'd1, 8'h01);
        wait_irq(10, "done_wait");
        cpu_done = 1'b1;
        step();
        cpu_done = 1'b0;
        chk("done_ign_irq", 32'(cpu_irq), 32'd1);
        peek(2'd2, 8'h80, "done_ign_stat");
        cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        peek(2'd2, 8'hC0, "serve_stat");

        // Asynchronous reset in SERVE
        rst = 1'b1;
        #1;
        chk("arst_irq", 32'(cpu_irq), 32'd0);
        peek(2'd2, 8'h00, "arst_stat");
        peek(2'd0, 8'h00, "arst_en");
        peek(2'd1, 8'h00, "arst_ctrl");
        step();
        rst = 1'b0;
        src_pend = 8'h00;
        step();

        // Randomized traffic
        bus_write(2'd0, 8'hFF);
        bus_write(2'd1, 8'h03);
        for (int i = 0; i < 4000; i++) begin
            src_pend = src_pend & ~src_clr;
            if ($urandom_range(0, 3) == 0) src_pend = src_pend | (8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 15) == 0) src_pend = src_pend & 8'($urandom);
            cpu_ack  = ($urandom_range(0, 2) == 0);
            cpu_done = ($urandom_range(0, 3) == 0);
            if (o_wb_ack || !i_wb_cyc) begin
                i_wb_cyc  = ($urandom_range(0, 5) == 0);
                i_wb_we   = 1'($urandom_range(0, 1));
                i_wb_addr = 2'($urandom_range(0, 3));
                i_wb_data = 8'($urandom);
                if (i_wb_addr == 2'd1) i_wb_data[0] = ($urandom_range(0, 7) != 0);
                if (i_wb_addr == 2'd0) i_wb_data = i_wb_data | 8'($urandom);
            end
            if (i == 2000) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            step();
        end
        cpu_ack = 1'b0; cpu_done = 1'b0; i_wb_cyc = 1'b0; i_wb_we = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
